// File: rtl/imem_loader.sv
// Byte-stream loader that packs big-endian words into instruction memory and holds the core's PC in clear until done.
// Latency: one cycle for start, four per word back-to-back, one RELEASE cycle; backpressure only via byte_ready (high in LOAD).
module imem_loader #(
  parameter int PCW = 6,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [PCW:0]   load_len,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid,
  output logic           byte_ready,
  output logic           imem_we,
  output logic [PCW-1:0] imem_addr,
  output logic [DW-1:0]  imem_wdata,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic [PCW:0]   words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  localparam logic [PCW:0] MAX_LEN = {1'b1, {PCW{1'b0}}};

  state_t         state_q, state_d;
  logic [PCW:0]   len_q, len_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [DW-9:0]  shift_q, shift_d;
  logic           we_q, we_d;
  logic [PCW-1:0] addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic [PCW:0]   wl_q, wl_d;

  logic           start_ok;
  logic           accept;
  logic           last_word;
  logic [PCW:0]   len_clamp;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == RUN));
  assign accept    = (state_q == LOAD) && byte_valid;
  assign last_word = accept && (cnt_q == 2'd3) && ((wl_q + (PCW+1)'(1)) == len_q);
  // Clamp keeps the write address inside the memory, so no wrap is possible.
  assign len_clamp = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      wl_q    <= wl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: if (start_ok) state_d = (len_clamp == '0) ? RELEASE : LOAD;
      LOAD:      if (last_word) state_d = RELEASE;
      RELEASE:   state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    wl_d    = wl_q;
    if (start_ok) begin
      len_d   = len_clamp;
      wl_d    = '0;
      cnt_d   = '0;
      shift_d = '0;
      hold_d  = 1'b1;
      done_d  = 1'b0;
    end
    if (accept) begin
      shift_d = {shift_q[DW-17:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        we_d    = 1'b1;
        wdata_d = {shift_q, byte_in};
        addr_d  = wl_q[PCW-1:0];
        wl_d    = wl_q + (PCW+1)'(1);
      end
    end
    // Hold drops on the RELEASE->RUN edge so the fetch after it sees the last word.
    if (state_q == RELEASE) begin
      hold_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_comb begin
    byte_ready = (state_q == LOAD);
    busy       = (state_q == LOAD) || (state_q == RELEASE);
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios, random loads against a stream-order word model, and reset/restart sequences.
module tb_imem_loader;
  localparam int PCW = 6;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           clr, start, byte_valid;
  logic [PCW:0]   load_len;
  logic [7:0]     byte_in;
  logic           byte_ready, imem_we, cpu_hold, busy, done;
  logic [PCW-1:0] imem_addr;
  logic [DW-1:0]  imem_wdata;
  logic [PCW:0]   words_loaded;

  imem_loader #(.PCW(PCW), .DW(DW)) dut (
    .clk(clk), .clr(clr), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [PCW-1:0] wq_addr[$];
  logic [DW-1:0]  wq_data[$];
  logic [7:0]     bytes [0:263];

  typedef struct {
    int len;
    int mode;        // 0 back-to-back, 1 toggling valid, 2 random valid
    bit fixed;
    int exp_writes;
  } vec_t;
  vec_t tbl [8];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s_hold", tag), cpu_hold, 1);
    chk($sformatf("%s_ready", tag), byte_ready, 0);
    chk($sformatf("%s_we", tag), imem_we, 0);
    chk($sformatf("%s_addr", tag), imem_addr, 0);
    chk($sformatf("%s_wdata", tag), imem_wdata, 0);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_done", tag), done, 0);
    chk($sformatf("%s_wl", tag), words_loaded, 0);
  endtask

  // Called and returns at posedge+1.
  task automatic run_load(input int len, input int mode, input bit fixed, input int exp_w, input string tag);
    int n, idx, acc_after;
    bit acc, timeout;
    logic [31:0] w;
    logic [7:0] fx [8];
    fx = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    for (int i = 0; i < 264; i++) bytes[i] = 8'($urandom);
    if (fixed) for (int i = 0; i < 8; i++) bytes[i] = fx[i];
    wq_addr.delete();
    wq_data.delete();
    start      = 1'b1;
    load_len   = len[PCW:0];
    byte_in    = bytes[0];
    byte_valid = (mode != 0);
    n = 0; idx = 0; timeout = 0;
    forever begin
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (acc) idx++;
      if (n == 1) chk($sformatf("%s_hold_on_start", tag), cpu_hold, 1);
      if (!cpu_hold) break;
      if (n > 4000) begin timeout = 1; break; end
      byte_in    = bytes[(idx < 264) ? idx : 263];
      byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((n % 2) == 1) : 1'($urandom_range(0, 1));
    end
    chk($sformatf("%s_timeout", tag), timeout, 0);
    chk($sformatf("%s_nwrites", tag), wq_addr.size(), exp_w);
    for (int i = 0; i < exp_w && i < wq_addr.size(); i++) begin
      w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
      chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), wq_data[i], w);
    end
    chk($sformatf("%s_consumed", tag), idx, 4*exp_w);
    chk($sformatf("%s_wl", tag), words_loaded, exp_w);
    chk($sformatf("%s_done", tag), done, 1);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_ready", tag), byte_ready, 0);
    if (mode == 0) chk($sformatf("%s_latency", tag), n, 2 + 4*exp_w);
    if (fixed && wq_data.size() >= 2) begin
      chk($sformatf("%s_w0", tag), wq_data[0], 32'h8C010004);
      chk($sformatf("%s_w1", tag), wq_data[1], 32'hAC020008);
    end
    byte_valid = 1'b1;
    acc_after = 0;
    repeat (4) begin
      @(negedge clk);
      if (byte_valid && byte_ready) acc_after++;
      @(posedge clk); #1;
    end
    chk($sformatf("%s_no_consume_run", tag), acc_after, 0);
    chk($sformatf("%s_no_extra_write", tag), wq_addr.size(), exp_w);
    chk($sformatf("%s_hold_run", tag), cpu_hold, 0);
    byte_valid = 1'b0;
  endtask

  initial begin
    int acc_idle, len, mode, expw;
    tbl[0] = '{len: 2,   mode: 0, fixed: 1, exp_writes: 2};
    tbl[1] = '{len: 2,   mode: 1, fixed: 1, exp_writes: 2};
    tbl[2] = '{len: 100, mode: 0, fixed: 0, exp_writes: 64};
    tbl[3] = '{len: 0,   mode: 0, fixed: 0, exp_writes: 0};
    tbl[4] = '{len: 5,   mode: 1, fixed: 0, exp_writes: 5};
    tbl[5] = '{len: 127, mode: 2, fixed: 0, exp_writes: 64};
    tbl[6] = '{len: 1,   mode: 0, fixed: 0, exp_writes: 1};
    tbl[7] = '{len: 64,  mode: 0, fixed: 0, exp_writes: 64};

    clr = 1'b0; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
    #2 clr = 1'b1;
    #1 chk_reset_vals("por");
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;

    // Idle with valid high and no start: nothing moves.
    byte_valid = 1'b1;
    acc_idle = 0;
    repeat (5) begin
      @(negedge clk);
      if (byte_valid && byte_ready) acc_idle++;
      @(posedge clk); #1;
    end
    chk("idle_no_consume", acc_idle, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", cpu_hold, 1);
    chk("idle_done", done, 0);

    // Clear mid-load after six bytes, then reload one word.
    start = 1'b1; load_len = 7'd3; byte_in = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("midload_wl", words_loaded, 1);
    chk("midload_busy", busy, 1);
    #3 clr = 1'b1;
    #1 chk_reset_vals("midclr");
    @(negedge clk) begin clr = 1'b0; byte_valid = 1'b0; end
    @(posedge clk); #1;
    run_load(1, 0, 0, 1, "after_clr");

    for (int t = 0; t < 8; t++)
      run_load(tbl[t].len, tbl[t].mode, tbl[t].fixed, tbl[t].exp_writes, $sformatf("tbl%0d", t));

    for (int r = 0; r < 6; r++) begin
      len  = $urandom_range(0, 127);
      mode = $urandom_range(0, 2);
      expw = (len > 64) ? 64 : len;
      run_load(len, mode, 0, expw, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream loader for the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit big-endian words. Each word is written into instruction memory at consecutive word addresses starting from 0. The core's PC is held in clear throughout the load and released once the last word has been written.

## Interface
- PCW, 6, instruction-memory address width in words (depth 2^PCW)
- DW, 32, instruction word width; fixed at 32 (4 bytes per word)

- clk  input  1  rising-edge clock
- clr  input  1  reset, asynchronous, active-high
- start  input  1  begin load; sampled only in IDLE and RUN
- load_len  input  PCW+1  number of words to load; sampled on accepted start
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  PCW  word address for the write
- imem_wdata  output  DW  assembled word
- cpu_hold  output  1  drives the core's PC clear input
- busy  output  1  high in LOAD or RELEASE
- done  output  1  high in RUN
- words_loaded  output  PCW+1  count of words written in the current or last load

## Operation
- States: IDLE, LOAD, RELEASE, RUN.
- Reset values: state=IDLE, cpu_hold=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, words_loaded=0. The byte counter and the shift register are also 0.
- IDLE, start=1:
  - Latch len = min(load_len, 2^PCW) and clear words_loaded and the byte counter.
  - cpu_hold stays 1.
  - If len=0, go to RELEASE; otherwise go to LOAD.
- LOAD:
  - byte_ready=1. A byte is accepted when byte_valid && byte_ready.
  - Byte 0 of each word lands in bits 31:24, byte 1 in 23:16, byte 2 in 15:8, byte 3 in 7:0.
  - On acceptance of byte 3:
    - imem_wdata <= assembled word; imem_addr <= words_loaded[PCW-1:0]; imem_we <= 1 for exactly one cycle.
    - words_loaded increments and the byte counter returns to 0.
  - If that word was word len-1, go to RELEASE; otherwise stay in LOAD.
  - A byte may be accepted in the same cycle that imem_we is high for the previous word.
- RELEASE:
  - byte_ready=0 and cpu_hold=1.
  - The state lasts exactly one cycle, then goes to RUN.
- RUN:
  - cpu_hold=0, done=1, byte_ready=0.
  - start=1 returns to LOAD, or to RELEASE if len=0, with the same latching as in IDLE.
  - cpu_hold is reasserted on the same edge.
- start in LOAD or RELEASE is ignored.
- byte_valid is ignored whenever byte_ready=0. No byte is consumed.
- A partial word is discarded on reset or on restart.
- load_len above 2^PCW is clamped; bytes after the final word are not accepted.
- Address wrap cannot occur, because the clamp bounds imem_addr to 2^PCW-1.
- clr mid-load:
  - Immediate return to IDLE with all reset values, including cpu_hold=1.
  - Memory contents already written are left as they are.

## Timing
- All outputs are registered except byte_ready and busy, which decode the current state.
- The final byte of word n is accepted at edge k. imem_we, imem_addr=n and imem_wdata are valid during cycle k..k+1, and the memory captures the word at edge k+1.
- Last word accepted at edge k:
  - RELEASE occupies cycle k..k+1.
  - cpu_hold falls and done rises at edge k+1.
  - The core's PC leaves clear from edge k+2, so the first instruction fetch sees the completed memory.
- Sustained throughput is one byte per cycle, which is one word every 4 cycles.
- Load latency from start to cpu_hold low is 1 + 4·len + 1 edges when bytes arrive back-to-back.
- start with len=0: cpu_hold falls 2 edges after start.

## Test plan
- Reset: assert clr asynchronously mid-cycle.
  - Outputs go to reset values immediately and cpu_hold=1.
  - Release clr and hold start=0: the block stays in IDLE.
- Two-word load, load_len=2, bytes 8C,01,00,04,AC,02,00,08 back-to-back:
  - imem_we pulses twice: addr0=8C010004 and addr1=AC020008.
  - words_loaded=2; cpu_hold falls 2 edges after the last byte.
- Throttled stream with byte_valid toggling every other cycle and byte_valid=1 in IDLE:
  - The same words are written.
  - No byte is consumed outside LOAD.
- load_len=100 with PCW=6:
  - Exactly 64 writes, to addresses 0..63.
  - byte_ready=0 after the 256th byte; done=1.
- clr after 6 bytes, then restart with load_len=1:
  - The partial word is discarded.
  - The first write goes to addr 0 with data from the new stream.
- Restart from RUN with start=1 and load_len=0:
  - cpu_hold returns to 1 on the start edge.
  - RELEASE, then RUN; no imem_we.
